// File: rtl/one_hot_dispatcher.sv
// one_hot_dispatcher: decodes accepted binary line indices into level-held one-hot
// pending requests, cleared per line by ACK; sticky ERR flags out-of-range indices.
`default_nettype none

module one_hot_dispatcher #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int INDEX_WIDTH  = $clog2(OUTPUT_WIDTH)
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [INDEX_WIDTH-1:0]   IDX,
  input  logic                     IDX_VALID,
  output logic                     IDX_READY,
  output logic [OUTPUT_WIDTH-1:0]  PEND,
  output logic [OUTPUT_WIDTH-1:0]  FIRE,
  input  logic [OUTPUT_WIDTH-1:0]  ACK,
  input  logic                     CLR_ALL,
  output logic                     BUSY,
  output logic [INDEX_WIDTH:0]     COUNT,
  output logic                     ERR,
  input  logic                     ERR_CLR
);

  logic [OUTPUT_WIDTH-1:0] pend_q, pend_d;
  logic [OUTPUT_WIDTH-1:0] fire_q, fire_d;
  logic [INDEX_WIDTH:0]    count_q, count_d;
  logic                    err_q, err_d;

  logic [OUTPUT_WIDTH-1:0] idx_onehot;
  logic [OUTPUT_WIDTH-1:0] set_mask;
  logic                    in_range;
  logic                    ready;
  logic                    accept;

  // Decoding by comparison keeps out-of-range indices from ever addressing PEND.
  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < OUTPUT_WIDTH; i++) begin
      idx_onehot[i] = (IDX == INDEX_WIDTH'(i));
    end
  end

  assign in_range = |idx_onehot;
  assign ready    = RESETN & ~CLR_ALL & ~(|(idx_onehot & pend_q));
  assign accept   = IDX_VALID & ready;
  assign set_mask = accept ? idx_onehot : '0;

  always_comb begin
    pend_d  = CLR_ALL ? '0 : ((pend_q & ~ACK) | set_mask);
    fire_d  = set_mask;
    err_d   = (err_q & ~ERR_CLR) | (accept & ~in_range);
    count_d = '0;
    for (int i = 0; i < OUTPUT_WIDTH; i++) begin
      count_d = count_d + (INDEX_WIDTH+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pend_q  <= '0;
      fire_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      fire_q  <= fire_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign IDX_READY = ready;
  assign PEND      = pend_q;
  assign FIRE      = fire_q;
  assign COUNT     = count_q;
  assign ERR       = err_q;
  assign BUSY      = |pend_q;

endmodule

`default_nettype wire

// File: tb/tb_one_hot_dispatcher.sv
// Directed table-driven bench for one_hot_dispatcher (16-line and 12-line instances).
`default_nettype none

module tb_one_hot_dispatcher;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // 16-line instance
  logic [3:0]  a_idx;
  logic        a_valid, a_ready, a_clr, a_busy, a_err, a_eclr;
  logic [15:0] a_pend, a_fire, a_ack;
  logic [4:0]  a_cnt;

  // 12-line instance
  logic [3:0]  b_idx;
  logic        b_valid, b_ready, b_clr, b_busy, b_err, b_eclr;
  logic [11:0] b_pend, b_fire, b_ack;
  logic [4:0]  b_cnt;

  one_hot_dispatcher #(.OUTPUT_WIDTH(16)) u_dut16 (
    .CLK(clk), .RESETN(rstn), .IDX(a_idx), .IDX_VALID(a_valid), .IDX_READY(a_ready),
    .PEND(a_pend), .FIRE(a_fire), .ACK(a_ack), .CLR_ALL(a_clr), .BUSY(a_busy),
    .COUNT(a_cnt), .ERR(a_err), .ERR_CLR(a_eclr)
  );

  one_hot_dispatcher #(.OUTPUT_WIDTH(12)) u_dut12 (
    .CLK(clk), .RESETN(rstn), .IDX(b_idx), .IDX_VALID(b_valid), .IDX_READY(b_ready),
    .PEND(b_pend), .FIRE(b_fire), .ACK(b_ack), .CLR_ALL(b_clr), .BUSY(b_busy),
    .COUNT(b_cnt), .ERR(b_err), .ERR_CLR(b_eclr)
  );

  typedef struct {
    bit          sel12;
    logic [3:0]  idx;
    logic        valid;
    logic [15:0] ack;
    logic        clr;
    logic        eclr;
    logic        exp_ready;
    logic [15:0] exp_pend;
    logic [15:0] exp_fire;
    logic [4:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_idx = '0; a_valid = 1'b0; a_ack = '0; a_clr = 1'b0; a_eclr = 1'b0;
    b_idx = '0; b_valid = 1'b0; b_ack = '0; b_clr = 1'b0; b_eclr = 1'b0;
  endtask

  task automatic add(input bit s, input logic [3:0] idx, input logic v, input logic [15:0] ack,
                     input logic clr, input logic eclr, input logic rdy, input logic [15:0] pend,
                     input logic [15:0] fire, input logic [4:0] cnt, input logic err);
    vec_t t;
    t.sel12 = s; t.idx = idx; t.valid = v; t.ack = ack; t.clr = clr; t.eclr = eclr;
    t.exp_ready = rdy; t.exp_pend = pend; t.exp_fire = fire; t.exp_cnt = cnt; t.exp_err = err;
    vecs.push_back(t);
  endtask

  task automatic apply(input int n, input vec_t t);
    @(negedge clk);
    idle_inputs();
    if (t.sel12) begin
      b_idx = t.idx; b_valid = t.valid; b_ack = t.ack[11:0]; b_clr = t.clr; b_eclr = t.eclr;
    end else begin
      a_idx = t.idx; a_valid = t.valid; a_ack = t.ack; a_clr = t.clr; a_eclr = t.eclr;
    end
    #1;
    check($sformatf("v%0d ready", n), t.sel12 ? 32'(b_ready) : 32'(a_ready), 32'(t.exp_ready));
    @(posedge clk);
    #1;
    if (t.sel12) begin
      check($sformatf("v%0d pend", n),  32'(b_pend), 32'(t.exp_pend[11:0]));
      check($sformatf("v%0d fire", n),  32'(b_fire), 32'(t.exp_fire[11:0]));
      check($sformatf("v%0d count", n), 32'(b_cnt),  32'(t.exp_cnt));
      check($sformatf("v%0d err", n),   32'(b_err),  32'(t.exp_err));
      check($sformatf("v%0d busy", n),  32'(b_busy), 32'(|t.exp_pend));
    end else begin
      check($sformatf("v%0d pend", n),  32'(a_pend), 32'(t.exp_pend));
      check($sformatf("v%0d fire", n),  32'(a_fire), 32'(t.exp_fire));
      check($sformatf("v%0d count", n), 32'(a_cnt),  32'(t.exp_cnt));
      check($sformatf("v%0d err", n),   32'(a_err),  32'(t.exp_err));
      check($sformatf("v%0d busy", n),  32'(a_busy), 32'(|t.exp_pend));
    end
  endtask

  initial begin
    //   sel idx  v  ack      clr ecl rdy pend     fire     cnt err
    add(0, 5,  1, 16'h0000, 0, 0, 1, 16'h0020, 16'h0020, 1, 0);
    add(0, 0,  0, 16'h0000, 0, 0, 1, 16'h0020, 16'h0000, 1, 0);
    add(0, 5,  1, 16'h0000, 0, 0, 0, 16'h0020, 16'h0000, 1, 0);
    add(0, 5,  1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 5,  1, 16'h0000, 0, 0, 1, 16'h0020, 16'h0020, 1, 0);
    add(0, 0,  0, 16'h0020, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 3,  1, 16'h0000, 0, 0, 1, 16'h0008, 16'h0008, 1, 0);
    add(0, 7,  1, 16'h0000, 0, 0, 1, 16'h0088, 16'h0080, 2, 0);
    add(0, 15, 1, 16'h0000, 0, 0, 1, 16'h8088, 16'h8000, 3, 0);
    add(0, 0,  0, 16'h8008, 0, 0, 1, 16'h0080, 16'h0000, 1, 0);
    add(0, 4,  1, 16'h0080, 0, 0, 1, 16'h0010, 16'h0010, 1, 0);
    add(0, 5,  1, 16'h0000, 0, 0, 1, 16'h0030, 16'h0020, 2, 0);
    add(0, 6,  1, 16'h0000, 0, 0, 1, 16'h0070, 16'h0040, 3, 0);
    add(0, 7,  1, 16'h0000, 0, 0, 1, 16'h00F0, 16'h0080, 4, 0);
    add(0, 2,  1, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 2,  1, 16'h0000, 0, 0, 1, 16'h0004, 16'h0004, 1, 0);
    add(0, 9,  1, 16'h0204, 0, 0, 1, 16'h0200, 16'h0200, 1, 0);
    add(1, 13, 1, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 0, 1);
    add(1, 0,  0, 16'h0000, 0, 1, 1, 16'h0000, 16'h0000, 0, 0);
    add(1, 14, 1, 16'h0000, 0, 1, 1, 16'h0000, 16'h0000, 0, 1);
    add(1, 11, 1, 16'h0000, 0, 0, 1, 16'h0800, 16'h0800, 1, 1);
    add(1, 12, 1, 16'h0000, 0, 1, 1, 16'h0800, 16'h0000, 1, 1);
    add(1, 11, 1, 16'h0000, 0, 1, 0, 16'h0800, 16'h0000, 1, 0);
    add(1, 13, 1, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0,  1, 16'h0000, 0, 0, 1, 16'h0001, 16'h0001, 1, 0);
    add(1, 8,  1, 16'h0000, 0, 0, 1, 16'h0101, 16'h0100, 2, 0);
    add(1, 15, 1, 16'h0000, 0, 0, 1, 16'h0101, 16'h0000, 2, 1);

    idle_inputs();
    rstn = 1'b0;
    #2;
    check("rst pend16",  32'(a_pend),  32'h0);
    check("rst fire16",  32'(a_fire),  32'h0);
    check("rst count16", 32'(a_cnt),   32'h0);
    check("rst err16",   32'(a_err),   32'h0);
    check("rst busy16",  32'(a_busy),  32'h0);
    check("rst ready16", 32'(a_ready), 32'h0);
    check("rst ready12", 32'(b_ready), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Mid-cycle async reset with dut12 holding PEND=0x0101 and ERR=1
    #2;
    idle_inputs();
    rstn = 1'b0;
    #1;
    check("async pend12",  32'(b_pend),  32'h0);
    check("async count12", 32'(b_cnt),   32'h0);
    check("async err12",   32'(b_err),   32'h0);
    check("async busy12",  32'(b_busy),  32'h0);
    check("async ready12", 32'(b_ready), 32'h0);
    check("async pend16",  32'(a_pend),  32'h0);
    @(negedge clk);
    rstn = 1'b1;
    b_idx = 4'd3; b_valid = 1'b1;
    #1;
    check("post-rst ready12", 32'(b_ready), 32'h1);
    @(posedge clk);
    #1;
    check("post-rst pend12", 32'(b_pend), 32'h008);
    check("post-rst fire12", 32'(b_fire), 32'h008);
    check("post-rst count12", 32'(b_cnt), 32'h1);
    idle_inputs();
    @(posedge clk);
    #1;
    check("post-rst fire drop12", 32'(b_fire), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
